// File: rtl/div_unit_pkg.sv
// Shared constants and state encodings for the iterative divide unit.
// Imported by div_unit and div_step.
package div_unit_pkg;

   localparam int              WORD      = 32;
   localparam logic [WORD-1:0] ZERO_WORD = '0;
   localparam logic            ENABLE    = 1'b1;
   localparam logic            DISABLE   = 1'b0;

   // EX-stage op codes that route to this unit (MIPS funct field)
   localparam logic [5:0] EX_OP_DIV  = 6'h1A;
   localparam logic [5:0] EX_OP_DIVU = 6'h1B;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_RUN  = 2'b01,
      DIV_DIV0 = 2'b10,
      DIV_DONE = 2'b11
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep the difference when it is non-negative.
module div_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem < divisor always holds, so {rem, bit} fits WIDTH+1 bits and the
   // sign of the trial difference is its top bit.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      if (!trial[WIDTH]) begin
         rem_nxt = trial[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_nxt = shifted[WIDTH-1:0];
         quo_nxt = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: stalls EX while iterating one quotient bit per
// cycle, then pulses the HI (remainder) / LO (quotient) write for one cycle.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int               WIDTH   = WORD,
   parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             busy,
   output logic             stall_req,
   output logic             o_we,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int             CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   div_state_e       state, state_nxt;
   logic [WIDTH-1:0] rem, quo, dvsr;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic [WIDTH-1:0] dvd_abs, dvs_abs;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic [CNT_W-1:0] count;
   logic             sign_q, sign_r;
   logic             accept, div_zero, last_step;

   assign accept    = start & ~cancel;
   assign div_zero  = (divisor == '0);
   assign last_step = (count == LAST);

   // Magnitudes are plain WIDTH-bit negation, so |MIN| stays MIN as unsigned
   assign dvd_abs = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_abs = (signed_div & divisor[WIDTH-1])  ? -divisor  : divisor;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (dvsr),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      stall_req = DISABLE;
      o_we      = DISABLE;
      case (state)
         DIV_IDLE: begin
            stall_req = accept;
            if (accept) state_nxt = div_zero ? DIV_DIV0 : DIV_RUN;
         end
         DIV_RUN: begin
            stall_req = ENABLE;
            if (cancel)         state_nxt = DIV_IDLE;
            else if (last_step) state_nxt = DIV_DONE;
         end
         DIV_DIV0: begin
            stall_req = ENABLE;
            state_nxt = cancel ? DIV_IDLE : DIV_DONE;
         end
         DIV_DONE: begin
            o_we      = ~cancel;
            state_nxt = DIV_IDLE;
         end
         default: state_nxt = DIV_IDLE;
      endcase
   end

   assign busy = (state != DIV_IDLE);
   assign o_hi = res_hi;
   assign o_lo = res_lo;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order of statements.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DIV_IDLE;
      else        state <= state_nxt;
   end

   // NOTE: the datapath is small and a mid-operation reset must leave no stale
   // result on o_hi/o_lo, so every register here is cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem    <= '0;
         quo    <= '0;
         dvsr   <= '0;
         count  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (accept) begin
                  sign_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  sign_r <= signed_div & dividend[WIDTH-1];
                  count  <= '0;
                  if (div_zero) begin
                     // DIV0 reports the raw dividend as the remainder
                     rem  <= dividend;
                     quo  <= '0;
                     dvsr <= '0;
                  end else begin
                     rem  <= '0;
                     quo  <= dvd_abs;
                     dvsr <= dvs_abs;
                  end
               end
            end
            DIV_RUN: begin
               if (!cancel) begin
                  rem   <= rem_nxt;
                  quo   <= quo_nxt;
                  count <= count + CNT_W'(1);
                  if (last_step) begin
                     res_hi <= sign_r ? -rem_nxt : rem_nxt;
                     res_lo <= sign_q ? -quo_nxt : quo_nxt;
                  end
               end
            end
            DIV_DIV0: begin
               if (!cancel) begin
                  res_hi <= rem;
                  res_lo <= DIV0_LO;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus queues expected HI/LO pairs, a
// negedge monitor pops and compares on every o_we pulse.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        cancel = 1'b0;
   logic        busy, stall_req, o_we;
   logic [31:0] o_hi, o_lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   div_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .signed_div (signed_div),
      .dividend   (dividend),
      .divisor    (divisor),
      .cancel     (cancel),
      .busy       (busy),
      .stall_req  (stall_req),
      .o_we       (o_we),
      .o_hi       (o_hi),
      .o_lo       (o_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs sampled at negedge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(negedge clk) begin
      if (o_we) begin
         if (sb.size() == 0) begin
            check("spurious_o_we", {31'b0, o_we}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("o_hi", o_hi, e.hi);
            check("o_lo", o_lo, e.lo);
         end
      end
   end

   task automatic run_div(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_edges, input bit hold);
      int edges = 0;
      int stalls = 0;
      exp_t e;
      e.hi = exp_hi;
      e.lo = exp_lo;
      sb.push_back(e);
      signed_div = sd;
      dividend   = a;
      divisor    = b;
      start      = 1'b1;
      #1;
      if (stall_req) stalls++;
      while (edges < 100) begin
         @(posedge clk);
         edges++;
         #2;
         if (!hold) start = 1'b0;
         if (o_we) break;
         if (stall_req) stalls++;
      end
      start = 1'b0;
      check({name, "_latency"}, edges, exp_edges);
      check({name, "_stall"}, stalls, exp_edges);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_we", {31'b0, o_we}, 32'd0);
      check("rst_hi", o_hi, 32'd0);
      check("rst_lo", o_lo, 32'd0);
      rst_n = 1'b1;
      tick();

      run_div("divu_100_7",   1'b0, 32'd100,      32'd7,          32'd2,          32'd14,         33, 1'b0);
      run_div("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   33, 1'b0);
      run_div("divu_m7_2",    1'b0, 32'hFFFFFFF9, 32'd2,          32'd1,          32'h7FFFFFFC,   33, 1'b0);
      run_div("div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   33, 1'b0);
      run_div("divu_5_0",     1'b0, 32'd5,        32'd0,          32'd5,          32'hFFFFFFFF,   2,  1'b0);
      run_div("div_m5_0",     1'b1, 32'hFFFFFFFB, 32'd0,          32'hFFFFFFFB,   32'hFFFFFFFF,   2,  1'b0);
      run_div("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   33, 1'b0);
      run_div("div_m8_m3",    1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD,   32'hFFFFFFFE,   32'd2,          33, 1'b0);
      run_div("divu_3_10",    1'b0, 32'd3,        32'd10,         32'd3,          32'd0,          33, 1'b0);
      run_div("divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,          32'd0,          32'hFFFFFFFF,   33, 1'b0);
      // start held high through RUN and DONE must not launch a second divide
      run_div("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'd0,          32'd1,          33, 1'b1);
      #1;
      check("held_start_idle", {31'b0, busy}, 32'd0);
      tick();

      // cancel in the tenth RUN cycle
      signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      cancel = 1'b1;
      #1;
      check("cancel_run_stall", {31'b0, stall_req}, 32'd1);
      tick();
      cancel = 1'b0;
      #1;
      check("cancel_busy", {31'b0, busy}, 32'd0);
      check("cancel_stall", {31'b0, stall_req}, 32'd0);
      #1;
      run_div("after_cancel", 1'b0, 32'd50, 32'd6, 32'd2, 32'd8, 33, 1'b0);

      // start and cancel together in IDLE
      start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd2;
      #1;
      check("start_cancel_stall", {31'b0, stall_req}, 32'd0);
      tick();
      start = 1'b0; cancel = 1'b0;
      #1;
      check("start_cancel_busy", {31'b0, busy}, 32'd0);
      tick();

      // cancel landing in the DONE cycle suppresses the write
      dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (busy && !stall_req) break;
         tick();
      end
      cancel = 1'b1;
      #1;
      check("done_cancel_we", {31'b0, o_we}, 32'd0);
      check("done_cancel_state", {31'b0, busy & ~stall_req}, 32'd1);
      tick();
      cancel = 1'b0;
      #1;
      check("done_cancel_idle", {31'b0, busy}, 32'd0);
      tick();

      // asynchronous reset pulse mid-RUN, leaving a prior result on o_hi/o_lo
      dividend = 32'd20; divisor = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_hi", o_hi, 32'd0);
      check("arst_lo", o_lo, 32'd0);
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_stall", {31'b0, stall_req}, 32'd0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      run_div("after_reset", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 33, 1'b0);

      for (int i = 0; i < 3; i++) tick();
      check("sb_drain", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
